// File: rtl/fetch_if.sv
// Fetch-stage bundle: ROM address/data, instruction register to decode, redirect and halt controls.
// The fetch unit drives the master side; the ROM, decode and branch logic sit on the slave side.
interface fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  pc_out;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] ir_out;
    logic [ADDR_W-1:0]  ir_pc;
    logic               ir_valid;
    logic               ir_ready;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_addr;
    logic               halt_req;
    logic               halted;
    logic [15:0]        fetch_count;

    modport master (
        output pc_out, ir_out, ir_pc, ir_valid, halted, fetch_count,
        input  rom_data, ir_ready, redirect_valid, redirect_addr, halt_req
    );

    modport slave (
        input  pc_out, ir_out, ir_pc, ir_valid, halted, fetch_count,
        output rom_data, ir_ready, redirect_valid, redirect_addr, halt_req
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, latches the ROM word into the IR, hands it to decode.
// Latency: first IR one edge after BOOT->RUN; redirect costs one bubble; 1 instr/cycle sustained.
// Backpressure: IR holds while ir_valid && !ir_ready; PC and counter freeze with it.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               load, flush, drain;

    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] ir_q;
    logic [ADDR_W-1:0]  ir_pc_q;
    logic               ir_vld_q;
    logic               halted_q;
    logic [15:0]        cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nxt;
    end

    // Redirect outranks everything, including a stalled IR and a pending halt.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        flush     = 1'b0;
        drain     = 1'b0;
        if (bus.redirect_valid) begin
            state_nxt = RUN;
            flush     = 1'b1;
        end else begin
            unique case (state)
                BOOT:   state_nxt = bus.halt_req ? HALTED : RUN;
                RUN: begin
                    if (bus.halt_req) begin
                        state_nxt = HALTED;
                        drain     = ir_vld_q && bus.ir_ready;
                    end else if (!ir_vld_q || bus.ir_ready) begin
                        load      = 1'b1;
                    end
                end
                HALTED: drain = ir_vld_q && bus.ir_ready;
                default: state_nxt = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            ir_pc_q  <= '0;
            ir_vld_q <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            halted_q <= (state_nxt == HALTED);
            if (flush) begin
                pc_q     <= bus.redirect_addr;
                ir_vld_q <= 1'b0;
            end else if (load) begin
                ir_q     <= bus.rom_data;
                ir_pc_q  <= pc_q;
                ir_vld_q <= 1'b1;
                pc_q     <= pc_q + ADDR_W'(1);
                if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            end else if (drain) begin
                ir_vld_q <= 1'b0;
            end
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.ir_out      = ir_q;
    assign bus.ir_pc       = ir_pc_q;
    assign bus.ir_valid    = ir_vld_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table walks reset, stall, redirect, wrap and halt;
// hand sequences cover counter saturation and asynchronous reset mid-stall.
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fetch_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

    fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [7:0] a);
        if (a == 8'h00) return 16'h47D2;
        if (a == 8'h01) return 16'hAF00;
        return {a, a ^ 8'hA5};
    endfunction

    assign bus.rom_data = rom_word(bus.pc_out);

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [7:0]  raddr;
        logic        halt;
        logic        vld;
        logic [15:0] ir;
        logic [7:0]  irpc;
        logic [7:0]  pc;
        logic        hlt;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rdy, input logic redir, input logic [7:0] raddr, input logic halt,
                       input logic vld, input logic [15:0] ir, input logic [7:0] irpc,
                       input logic [7:0] pc, input logic hlt, input logic [15:0] cnt);
        vec_t v;
        v.rdy = rdy; v.redir = redir; v.raddr = raddr; v.halt = halt;
        v.vld = vld; v.ir = ir; v.irpc = irpc; v.pc = pc; v.hlt = hlt; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic vld, input logic [15:0] ir, input logic [7:0] irpc,
                           input logic [7:0] pc, input logic hlt, input logic [15:0] cnt);
        chk({tag, " ir_valid"},    32'(bus.ir_valid),    32'(vld));
        chk({tag, " ir_out"},      32'(bus.ir_out),      32'(ir));
        chk({tag, " ir_pc"},       32'(bus.ir_pc),       32'(irpc));
        chk({tag, " pc_out"},      32'(bus.pc_out),      32'(pc));
        chk({tag, " halted"},      32'(bus.halted),      32'(hlt));
        chk({tag, " fetch_count"}, 32'(bus.fetch_count), 32'(cnt));
    endtask

    task automatic drive(input logic rdy, input logic redir, input logic [7:0] raddr, input logic halt);
        bus.ir_ready       = rdy;
        bus.redirect_valid = redir;
        bus.redirect_addr  = raddr;
        bus.halt_req       = halt;
    endtask

    initial begin
        int cyc;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 8'h00, 1'b0);

        //   rdy redir raddr  halt  vld  ir        irpc   pc     hlt  cnt
        add(1, 0, 8'h00, 0,   0, 16'h0000, 8'h00, 8'h00, 0, 16'd0);   // BOOT -> RUN
        add(1, 0, 8'h00, 0,   1, 16'h47D2, 8'h00, 8'h01, 0, 16'd1);
        add(0, 0, 8'h00, 0,   1, 16'h47D2, 8'h00, 8'h01, 0, 16'd1);   // stall x3
        add(0, 0, 8'h00, 0,   1, 16'h47D2, 8'h00, 8'h01, 0, 16'd1);
        add(0, 0, 8'h00, 0,   1, 16'h47D2, 8'h00, 8'h01, 0, 16'd1);
        add(1, 0, 8'h00, 0,   1, 16'hAF00, 8'h01, 8'h02, 0, 16'd2);
        add(1, 0, 8'h00, 0,   1, 16'h02A7, 8'h02, 8'h03, 0, 16'd3);
        add(1, 1, 8'h10, 0,   0, 16'h02A7, 8'h02, 8'h10, 0, 16'd3);
        add(0, 0, 8'h00, 0,   1, 16'h10B5, 8'h10, 8'h11, 0, 16'd4);
        add(0, 0, 8'h00, 0,   1, 16'h10B5, 8'h10, 8'h11, 0, 16'd4);
        add(0, 1, 8'h00, 0,   0, 16'h10B5, 8'h10, 8'h00, 0, 16'd4);   // redirect over stall
        add(0, 0, 8'h00, 0,   1, 16'h47D2, 8'h00, 8'h01, 0, 16'd5);
        add(1, 1, 8'hFE, 0,   0, 16'h47D2, 8'h00, 8'hFE, 0, 16'd5);
        add(1, 0, 8'h00, 0,   1, 16'hFE5B, 8'hFE, 8'hFF, 0, 16'd6);   // PC wrap
        add(1, 0, 8'h00, 0,   1, 16'hFF5A, 8'hFF, 8'h00, 0, 16'd7);
        add(1, 0, 8'h00, 0,   1, 16'h47D2, 8'h00, 8'h01, 0, 16'd8);
        add(1, 0, 8'h00, 0,   1, 16'hAF00, 8'h01, 8'h02, 0, 16'd9);
        add(0, 0, 8'h00, 0,   1, 16'hAF00, 8'h01, 8'h02, 0, 16'd9);
        add(0, 0, 8'h00, 1,   1, 16'hAF00, 8'h01, 8'h02, 1, 16'd9);   // halt while stalled
        add(0, 0, 8'h00, 0,   1, 16'hAF00, 8'h01, 8'h02, 1, 16'd9);
        add(1, 0, 8'h00, 0,   0, 16'hAF00, 8'h01, 8'h02, 1, 16'd9);
        add(1, 0, 8'h00, 0,   0, 16'hAF00, 8'h01, 8'h02, 1, 16'd9);
        add(1, 0, 8'h00, 1,   0, 16'hAF00, 8'h01, 8'h02, 1, 16'd9);
        add(1, 1, 8'h05, 0,   0, 16'hAF00, 8'h01, 8'h05, 0, 16'd9);
        add(1, 0, 8'h00, 0,   1, 16'h05A0, 8'h05, 8'h06, 0, 16'd10);
        add(1, 1, 8'h20, 1,   0, 16'h05A0, 8'h05, 8'h20, 0, 16'd10);  // redirect beats halt
        add(1, 0, 8'h00, 0,   1, 16'h2085, 8'h20, 8'h21, 0, 16'd11);
        add(1, 0, 8'h00, 1,   0, 16'h2085, 8'h20, 8'h21, 1, 16'd11);
        add(1, 1, 8'h00, 0,   0, 16'h2085, 8'h20, 8'h00, 0, 16'd11);

        #2;
        chk_all("reset", 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 16'd0);
        #10 rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].rdy, tbl[i].redir, tbl[i].raddr, tbl[i].halt);
            @(posedge clk);
            #1;
            chk_all($sformatf("row%0d", i), tbl[i].vld, tbl[i].ir, tbl[i].irpc,
                    tbl[i].pc, tbl[i].hlt, tbl[i].cnt);
        end

        // Saturation: one BOOT edge then one load per edge until the counter reads FFFE.
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (cyc < 70000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.fetch_count == 16'hFFFE) break;
        end
        chk("cycles to FFFE", 32'(cyc), 32'd65535);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d fetch_count", k), 32'(bus.fetch_count), 32'hFFFF);
            chk($sformatf("sat%0d ir_valid", k), 32'(bus.ir_valid), 32'd1);
        end

        // Async reset in the middle of a stall, sampled before the next edge.
        bus.ir_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("stall ir_valid", 32'(bus.ir_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk_all("midreset", 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the combinational instruction ROM and directly upstream of decode. It owns the program counter and drives the ROM address. It latches the returned 16-bit word into an instruction register and presents it to decode over a valid/ready handshake. It also handles jump/branch redirects, halt, and a saturating fetch counter.

## Interface
- ADDR_W, 8, PC / ROM address width
- INSTR_W, 16, instruction width
- RESET_PC, 8'h00, PC value after reset and in BOOT
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- pc_out  output  ADDR_W  registered PC; ROM address
- rom_data  input  INSTR_W  ROM word for pc_out (combinational, valid same cycle)
- ir_out  output  INSTR_W  instruction register to decode
- ir_pc  output  ADDR_W  address ir_out was fetched from
- ir_valid  output  1  ir_out holds an unconsumed instruction
- ir_ready  input  1  decode accepts ir_out this cycle
- redirect_valid  input  1  jump/branch taken; load redirect_addr
- redirect_addr  input  ADDR_W  target PC
- halt_req  input  1  stop fetching (single-cycle or level)
- halted  output  1  fetch unit is in HALTED
- fetch_count  output  16  instructions loaded into IR, saturating

One clock; reset is asynchronous and active-low.

## Operation
- States: BOOT, RUN, HALTED.
- Reset values (async, on rst_n=0):
  - state=BOOT, pc_out=RESET_PC, ir_out=16'h0000 (NOP), ir_pc=0.
  - ir_valid=0, halted=0, fetch_count=0.
- BOOT: no fetch, PC holds. The next edge goes to RUN unless redirect_valid or halt_req wins.
- load condition: state==RUN && (!ir_valid || ir_ready) && !redirect_valid.
- On load:
  - ir_out<=rom_data, ir_pc<=pc_out, ir_valid<=1.
  - pc_out<=pc_out+1, modulo 2^ADDR_W (8'hFF wraps to 8'h00).
  - fetch_count<=fetch_count+1, saturating at 16'hFFFF.
- RUN with ir_valid && !ir_ready: everything holds (stall); ir_out/ir_pc stay stable until accepted.
- RUN with ir_valid && ir_ready and no load (HALTED path): ir_valid<=0.
- Redirect, any state, highest priority:
  - pc_out<=redirect_addr, ir_valid<=0 (flush), state<=RUN, halted<=0.
  - The word currently on ir_out is treated as consumed, regardless of ir_ready.
- Halt: halt_req in RUN with no redirect → state<=HALTED, halted<=1. No load happens that cycle.
- HALTED:
  - PC frozen, no loads.
  - A pending ir_valid stays until ir_ready, then clears.
  - Exits only via redirect_valid.
  - halt_req has no effect while HALTED.
- Simultaneous redirect_valid and halt_req: redirect wins; state RUN.
- Simultaneous redirect_valid and stall: redirect wins; IR flushed.
- fetch_count never wraps and is cleared only by reset.

## Timing
- pc_out, ir_*, halted, fetch_count are all registered; no combinational input→output paths.
- Reset release → first edge: BOOT→RUN. Second edge: first load (ir_valid=1, ir_out=ROM[RESET_PC]).
- Sustained throughput with ir_ready=1: one instruction per cycle.
- Redirect asserted in cycle N:
  - ir_valid=0 in N+1; pc_out=redirect_addr in N+1.
  - ir_out=ROM[target] with ir_valid=1 in N+2 (one bubble).
- halt_req in cycle N: halted=1 in N+1; no new load from N onward.
- Reset asserted mid-operation: all outputs go to reset values immediately; in-flight IR is discarded.

## Test plan
- Reset release with ROM[0]=16'h47D2, ROM[1]=16'hAF00, ir_ready=1 → ir_out=16'h47D2/ir_pc=0 on 2nd edge, 16'hAF00/ir_pc=1 on 3rd; fetch_count=2.
- ir_ready held 0 for 3 cycles after first load → ir_out, ir_pc, pc_out, fetch_count unchanged. Release → next word in the following cycle with no skip or duplicate.
- redirect_valid with redirect_addr=8'h00 while pc_out=8'h11 and ir_ready=0 → ir_valid=0 next cycle; ir_pc=0 with ROM[0] the cycle after.
- Run sequentially from PC 8'hFE → ir_pc sequence 8'hFE, 8'hFF, 8'h00, 8'h01 (wrap).
- halt_req pulse with IR stalled → halted=1, ir_valid stays 1 until ir_ready, then 0; pc_out frozen. Later redirect_valid to 8'h05 → halted=0, ROM[5] delivered two cycles later. Same-cycle halt_req+redirect_valid → RUN, halted stays 0.
- Force fetch_count to 16'hFFFE, run 3 loads → stays at 16'hFFFF. Assert rst_n=0 mid-stall → all outputs at reset values before the next clock edge.
